// File: rtl/ram_stream_reader_pkg.sv
// Shared definitions for the RAM stream reader.
// Holds the controller state encoding and the output FIFO sizing constants.

package ram_stream_reader_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StDone
  } state_e;

  // Output FIFO depth; reads are throttled so that buffered plus in-flight words never exceed it.
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned FIFO_OCC_W = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/ram_stream_reader_if.sv
// Bus bundle for the RAM stream reader.
// Groups the RAM read port and the outgoing valid/ready word stream.
//   read_en / read_address : read request towards the RAM (1-cycle read latency)
//   read_data_out          : RAM read data, valid the cycle after read_en
//   m_valid / m_ready      : output stream handshake
//   m_data / m_last        : output stream word and end-of-burst marker
// master: the reader side. slave: the RAM plus stream consumer side.

interface ram_stream_reader_if #(
  parameter int unsigned WIDTH      = 72,
  parameter int unsigned DEPTH_BITS = 12
) ();

  logic                  read_en;
  logic [DEPTH_BITS-1:0] read_address;
  logic [WIDTH-1:0]      read_data_out;
  logic                  m_valid;
  logic                  m_ready;
  logic [WIDTH-1:0]      m_data;
  logic                  m_last;

  modport master (
    output read_en,
    output read_address,
    input  read_data_out,
    output m_valid,
    input  m_ready,
    output m_data,
    output m_last
  );

  modport slave (
    input  read_en,
    input  read_address,
    output read_data_out,
    input  m_valid,
    output m_ready,
    input  m_data,
    input  m_last
  );

endinterface

// File: rtl/ram_stream_reader_stream_fifo.sv
// stream_fifo: small synchronous FIFO with the head word driven straight from storage flops.
//   clk, rst          : clock and synchronous active-high reset (flushes contents)
//   push, push_data   : write one word (ignored when full)
//   pop               : consume the head word (ignored when empty)
//   full, empty       : status flags
//   occupancy         : number of stored words, registered
//   pop_data          : head word; stays stable until popped

module stream_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [WIDTH-1:0]           pop_data
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OccW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q;
  logic [PtrW-1:0]  rd_ptr_q;
  logic [OccW-1:0]  occ_q;
  logic             push_ok;
  logic             pop_ok;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(DEPTH - 1)) begin
      return '0;
    end
    return p + PtrW'(1);
  endfunction

  assign full      = (occ_q == OccW'(DEPTH));
  assign empty     = (occ_q == '0);
  assign occupancy = occ_q;
  assign pop_data  = mem_q[rd_ptr_q];
  assign push_ok   = push && !full;
  assign pop_ok    = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      // Storage is cleared too so the head word reads as zero after reset.
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop_ok) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      unique case ({push_ok, pop_ok})
        2'b10:   occ_q <= occ_q + OccW'(1);
        2'b01:   occ_q <= occ_q - OccW'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

endmodule

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: streams a burst of consecutive RAM words out over a valid/ready interface.
//   clk, rst   : clock and synchronous active-high reset
//   start      : one-cycle burst request, only honoured while idle
//   base_addr  : first RAM address of the burst (wraps at 2^DEPTH_BITS)
//   count      : burst length, 0..2^DEPTH_BITS
//   busy       : high whenever the controller is not idle
//   done       : one-cycle pulse when the burst has been fully delivered
//   bus        : RAM read port and output stream (master side)
// Reads are issued only while buffered plus in-flight words stay below the FIFO depth, so the
// FIFO can never overflow and m_ready never reaches the read port combinationally.

module ram_stream_reader
  import ram_stream_reader_pkg::*;
#(
  parameter int unsigned WIDTH      = 72,
  parameter int unsigned DEPTH_BITS = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DEPTH_BITS-1:0] base_addr,
  input  logic [DEPTH_BITS:0]   count,
  output logic                  busy,
  output logic                  done,
  ram_stream_reader_if.master   bus
);

  localparam int unsigned CntW = DEPTH_BITS + 1;

  state_e                  state_q, state_d;
  logic [DEPTH_BITS-1:0]   base_q, base_d;
  logic [CntW-1:0]         count_q, count_d;
  logic [CntW-1:0]         issued_q, issued_d;
  logic [CntW-1:0]         delivered_q, delivered_d;
  logic                    inflight_q;
  logic                    inflight_last_q;

  logic                    read_en;
  logic                    issue_last;
  logic                    can_issue;
  logic                    handshake;
  logic [FIFO_OCC_W-1:0]   pending;

  logic                    fifo_full;
  logic                    fifo_empty;
  logic [FIFO_OCC_W-1:0]   fifo_occ;
  logic [WIDTH:0]          fifo_out;

  // Only registered state feeds the issue decision.
  assign pending    = fifo_occ + FIFO_OCC_W'(inflight_q);
  assign can_issue  = (pending < FIFO_OCC_W'(FIFO_DEPTH)) && !fifo_full;
  assign issue_last = (issued_q == count_q - CntW'(1));
  assign handshake  = !fifo_empty && bus.m_ready;

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    count_d     = count_q;
    issued_d    = issued_q;
    delivered_d = delivered_q;
    read_en     = 1'b0;

    if (handshake) begin
      delivered_d = delivered_q + CntW'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          base_d      = base_addr;
          count_d     = count;
          issued_d    = '0;
          delivered_d = '0;
          state_d     = (count != '0) ? StIssue : StDone;
        end
      end
      StIssue: begin
        if (can_issue) begin
          read_en  = 1'b1;
          issued_d = issued_q + CntW'(1);
          if (issue_last) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (handshake && (delivered_q == count_q - CntW'(1))) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      base_q          <= '0;
      count_q         <= '0;
      issued_q        <= '0;
      delivered_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      base_q          <= base_d;
      count_q         <= count_d;
      issued_q        <= issued_d;
      delivered_q     <= delivered_d;
      // RAM data returns one cycle after the read, tagged with its end-of-burst flag.
      inflight_q      <= read_en;
      inflight_last_q <= read_en && issue_last;
    end
  end

  stream_fifo #(
    .WIDTH (WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_data ({inflight_last_q, bus.read_data_out}),
    .pop       (handshake),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .occupancy (fifo_occ),
    .pop_data  (fifo_out)
  );

  assign bus.read_en      = read_en;
  assign bus.read_address = base_q + issued_q[DEPTH_BITS-1:0];
  assign bus.m_valid      = !fifo_empty;
  assign bus.m_data       = fifo_out[WIDTH-1:0];
  assign bus.m_last       = fifo_out[WIDTH];
  assign busy             = (state_q != StIdle);
  assign done             = (state_q == StDone);

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed testbench for ram_stream_reader. RAM model returns data = address.

module tb_ram_stream_reader;

  localparam int unsigned W  = 72;
  localparam int unsigned DB = 12;

  logic          clk;
  logic          rst;
  logic          start;
  logic [DB-1:0] base_addr;
  logic [DB:0]   count;
  logic          busy;
  logic          done;

  ram_stream_reader_if #(.WIDTH(W), .DEPTH_BITS(DB)) bus ();

  ram_stream_reader #(.WIDTH(W), .DEPTH_BITS(DB)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .bus       (bus)
  );

  function automatic logic [W-1:0] ram_word(input logic [DB-1:0] a);
    return W'(a);
  endfunction

  // Synchronous RAM, one-cycle read latency.
  always @(posedge clk) begin
    if (bus.read_en) bus.read_data_out <= ram_word(bus.read_address);
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Captured activity, cleared at each burst start.
  logic [DB-1:0] addr_q[$];
  logic [W-1:0]  data_q[$];
  bit            last_q[$];
  int            hs_cyc_q[$];
  int done_cnt, done_cyc, busy_cnt, valid_cnt, ovf_cnt, unstable_cnt, start_cyc;
  int tb_occ, tb_inflight;
  bit            stall_prev;
  logic [W-1:0]  prev_data;
  logic          prev_last;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Monitor sampling at the falling edge; keeps its own FIFO occupancy model.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      tb_occ      = 0;
      tb_inflight = 0;
      stall_prev  = 1'b0;
    end else begin
      if (bus.read_en) begin
        addr_q.push_back(bus.read_address);
        if (tb_occ + tb_inflight >= 4) ovf_cnt++;
      end
      if (stall_prev && (!bus.m_valid || bus.m_data !== prev_data || bus.m_last !== prev_last))
        unstable_cnt++;
      if (bus.m_valid && bus.m_ready) begin
        data_q.push_back(bus.m_data);
        last_q.push_back(bus.m_last);
        hs_cyc_q.push_back(cyc);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (busy) busy_cnt++;
      if (bus.m_valid) valid_cnt++;
      stall_prev  = bus.m_valid && !bus.m_ready;
      prev_data   = bus.m_data;
      prev_last   = bus.m_last;
      tb_occ      = tb_occ + tb_inflight - ((bus.m_valid && bus.m_ready) ? 1 : 0);
      tb_inflight = bus.read_en ? 1 : 0;
    end
  end

  task automatic kick(input logic [DB-1:0] b, input int n);
    addr_q.delete();
    data_q.delete();
    last_q.delete();
    hs_cyc_q.delete();
    done_cnt     = 0;
    busy_cnt     = 0;
    valid_cnt    = 0;
    ovf_cnt      = 0;
    unstable_cnt = 0;
    base_addr    = b;
    count        = (DB+1)'(n);
    start        = 1'b1;
    start_cyc    = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input bit rand_ready, input int repulse_at);
    for (int i = 0; i < 300; i++) begin
      if (done_cnt != 0) break;
      if (rand_ready) bus.m_ready = 1'($urandom_range(0, 1));
      if (i == repulse_at) begin
        start     = 1'b1;
        base_addr = 12'h700;
        count     = 13'd3;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    start       = 1'b0;
    bus.m_ready = 1'b1;
    check("done_seen", 128'(done_cnt != 0), 128'(1));
    repeat (3) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_burst(input logic [DB-1:0] b, input int n);
    logic [DB-1:0] a;
    check("n_reads", 128'(addr_q.size()), 128'(n));
    check("n_words", 128'(data_q.size()), 128'(n));
    for (int i = 0; i < n; i++) begin
      a = b + DB'(i);
      if (i < addr_q.size()) check("rd_addr", 128'(addr_q[i]), 128'(a));
      if (i < data_q.size()) begin
        check("m_data", 128'(data_q[i]), 128'(ram_word(a)));
        check("m_last", 128'(last_q[i]), 128'(i == n - 1));
      end
    end
    check("done_pulses", 128'(done_cnt), 128'(1));
    if (hs_cyc_q.size() > 0) check("done_lat", 128'(done_cyc), 128'(hs_cyc_q[$] + 1));
    check("no_overflow", 128'(ovf_cnt), 128'(0));
    check("stall_stable", 128'(unstable_cnt), 128'(0));
  endtask

  task automatic check_reset_outputs();
    check("rst_read_en", 128'(bus.read_en), 128'(0));
    check("rst_read_addr", 128'(bus.read_address), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    check("rst_m_valid", 128'(bus.m_valid), 128'(0));
    check("rst_m_last", 128'(bus.m_last), 128'(0));
    check("rst_m_data", 128'(bus.m_data), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    base_addr   = '0;
    count       = '0;
    bus.m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    rst = 1'b0;

    // Basic burst, start in the first cycle after reset release, full rate.
    kick(12'h010, 5);
    wait_done(1'b0, -1);
    check_burst(12'h010, 5);
    for (int i = 1; i < hs_cyc_q.size(); i++)
      check("back_to_back", 128'(hs_cyc_q[i]), 128'(hs_cyc_q[i-1] + 1));
    check("first_latency", 128'(hs_cyc_q.size() > 0 ? hs_cyc_q[0] : -1), 128'(start_cyc + 3));

    // Address wrap.
    kick(12'hFFE, 4);
    wait_done(1'b0, -1);
    check_burst(12'hFFE, 4);

    // Random backpressure.
    kick(12'h040, 8);
    wait_done(1'b1, -1);
    check_burst(12'h040, 8);

    // Empty burst.
    kick(12'h123, 0);
    wait_done(1'b0, -1);
    check("zero_reads", 128'(addr_q.size()), 128'(0));
    check("zero_valid", 128'(valid_cnt), 128'(0));
    check("zero_busy", 128'(busy_cnt), 128'(1));
    check("zero_done", 128'(done_cnt), 128'(1));
    check("zero_done_cyc", 128'(done_cyc), 128'(start_cyc + 1));

    // Start re-pulsed mid-burst with another base is ignored.
    kick(12'h100, 6);
    wait_done(1'b0, 2);
    check_burst(12'h100, 6);

    // Reset after the third word: no done, reset outputs, then a clean burst.
    kick(12'h200, 6);
    for (int i = 0; i < 100; i++) begin
      if (data_q.size() >= 3) break;
      @(posedge clk);
      #1;
    end
    check("abort_progress", 128'(data_q.size() >= 3), 128'(1));
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs();
    @(posedge clk);
    #1;
    check("abort_no_done", 128'(done_cnt), 128'(0));
    rst = 1'b0;
    kick(12'h300, 3);
    wait_done(1'b0, -1);
    check_burst(12'h300, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ram_stream_reader.md
RAM_STREAM_READER -- requirements
Module: ram_stream_reader

Interface
REQ-001 Parameter WIDTH, default 72, word width; matches the RAM data width.
REQ-002 Parameter DEPTH_BITS, default 12, RAM address width.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 start  input  1  single-cycle request to stream one burst; sampled only in IDLE.
REQ-006 base_addr  input  DEPTH_BITS  first RAM address of the burst; latched on accepted start.
REQ-007 count  input  DEPTH_BITS+1  number of words in the burst (0..2^DEPTH_BITS); latched on accepted start.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 done  output  1  one-cycle pulse at burst completion.
REQ-010 read_en  output  1  RAM read enable.
REQ-011 read_address  output  DEPTH_BITS  RAM read address.
REQ-012 read_data_out  input  WIDTH  RAM read data; valid the cycle after read_en.
REQ-013 m_valid  output  1  output stream valid.
REQ-014 m_ready  input  1  output stream ready.
REQ-015 m_data  output  WIDTH  output stream word.
REQ-016 m_last  output  1  high with the final word of the burst.

Function
REQ-017 FSM states: IDLE, ISSUE, DRAIN, DONE.
REQ-018 IDLE: start=1 latches base_addr/count; next state ISSUE if count>0, else DONE.
REQ-019 ISSUE: read_en=1 when (FIFO occupancy + reads in flight) < 4; read_address = base_addr + issued count, modulo 2^DEPTH_BITS (wraps 2^DEPTH_BITS-1 -> 0).
REQ-020 Data from a read issued in cycle T is written into the 4-entry output FIFO at the end of T+1. It appears on m_data/m_valid no earlier than T+2.
REQ-021 ISSUE -> DRAIN in the cycle after the count-th read is issued. DRAIN -> DONE in the cycle after the last word handshakes (m_valid & m_ready).
REQ-022 DONE: done=1 for exactly one cycle, then IDLE.
REQ-023 Words are delivered in address order with no loss or duplication under arbitrary m_ready. m_data and m_last stay stable while m_valid=1 and m_ready=0.
REQ-024 m_ready has no combinational path to read_en or read_address. Issue gating uses registered occupancy only.
REQ-025 With m_ready held at 1, the sustained rate is one word per cycle after the first word.
REQ-026 start while busy=1 is ignored and does not affect the current burst.
REQ-027 read_en=0 in IDLE, DRAIN and DONE. The FIFO never overflows.
REQ-028 count=0 produces no read_en and no m_valid; done pulses in the cycle after start.

Reset
REQ-029 On rst=1: state IDLE, FIFO flushed, in-flight read discarded.
REQ-030 On rst=1, outputs read_en=0, read_address=0, busy=0, done=0, m_valid=0, m_last=0 and m_data=0.
REQ-031 rst mid-burst aborts the burst with no done pulse. A start in the first cycle after rst deasserts is accepted.

Structure
REQ-032 A shared package holds the state enum and the constant FIFO_DEPTH=4.
REQ-033 One sub-module, stream_fifo, is used: synchronous FIFO with parameters WIDTH and depth, push/pop/full/empty/occupancy, and a registered output. It is instantiated for {m_last, data}.
REQ-034 The remainder of the block (FSM, issue counter, in-flight flag, delivered counter) is implemented in ram_stream_reader.

Verification
REQ-035 base=0x010, count=5, m_ready=1, RAM preloaded with data = address: m_data shows 0x010..0x014 on consecutive cycles; m_last only on 0x014; done 1 cycle after the last handshake.
REQ-036 base=0xFFE, count=4 (DEPTH_BITS=12): read_address sequence is 0xFFE, 0xFFF, 0x000, 0x001; data is delivered in that order.
REQ-037 count=8 with m_ready toggling at random (50%): all 8 words are delivered in order; read_en never issues with occupancy + in-flight = 4; m_data is stable while stalled.
REQ-038 count=0: no read_en and no m_valid; busy is high for 1 cycle; done pulses 1 cycle after start.
REQ-039 start re-pulsed mid-burst with a different base: ignored, and the original burst completes intact. rst asserted at word 3 of 6: outputs go to reset values and there is no done pulse; a new burst afterwards runs correctly.
